// File: rtl/ram_arb_pkg.sv
// Shared constants and types for the two-requester RAM arbiter.
package ram_arb_pkg;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_ADDR_WIDTH = 4;

  typedef logic port_id_t;

  localparam logic OP_READ  = 1'b0;
  localparam logic OP_WRITE = 1'b1;

endpackage

// File: rtl/rr_arb2.sv
// Two-input grant logic with a round-robin priority register.
// Defining RAM_ARB_FIXED_PRIO_EN replaces it with fixed port-0 priority and no register.
module rr_arb2
  import ram_arb_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  output logic [1:0] gnt,
  output port_id_t   gnt_id,
  output logic       gnt_any
);

`ifdef RAM_ARB_FIXED_PRIO_EN
  always_comb begin
    gnt = 2'b00;
    if (rst_n) begin
      if (req[0]) gnt = 2'b01;
      else if (req[1]) gnt = 2'b10;
    end
  end
`else
  port_id_t prio_reg;
  port_id_t prio_next;

  always_ff @(posedge clk) begin
    if (!rst_n) prio_reg <= 1'b0;
    else        prio_reg <= prio_next;
  end

  // The port that just won yields priority to the other one.
  always_comb begin
    gnt       = 2'b00;
    prio_next = prio_reg;
    if (rst_n) begin
      case (req)
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
        2'b11:   gnt = prio_reg ? 2'b10 : 2'b01;
        default: gnt = 2'b00;
      endcase
      if (gnt[0])      prio_next = 1'b1;
      else if (gnt[1]) prio_next = 1'b0;
    end
  end
`endif

  assign gnt_any = |gnt;
  assign gnt_id  = gnt[1];

endmodule

// File: rtl/ram_arbiter.sv
// Shares one single-port registered-read RAM between two requesters.
// Build option RAM_ARB_FIXED_PRIO_EN selects fixed port-0 priority in rr_arb2.
module ram_arbiter
  import ram_arb_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req0_valid,
  output logic                  req0_ready,
  input  logic                  req0_we,
  input  logic [ADDR_WIDTH-1:0] req0_addr,
  input  logic [DATA_WIDTH-1:0] req0_wdata,
  input  logic                  req1_valid,
  output logic                  req1_ready,
  input  logic                  req1_we,
  input  logic [ADDR_WIDTH-1:0] req1_addr,
  input  logic [DATA_WIDTH-1:0] req1_wdata,
  output logic                  rsp0_valid,
  output logic [DATA_WIDTH-1:0] rsp0_rdata,
  output logic                  rsp1_valid,
  output logic [DATA_WIDTH-1:0] rsp1_rdata,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_din,
  input  logic [DATA_WIDTH-1:0] ram_dout
);

  logic [1:0]            gnt;
  port_id_t              gnt_id;
  logic                  gnt_any;
  logic                  sel_we;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_wdata;

  logic                  ram_we_reg;
  logic [ADDR_WIDTH-1:0] ram_addr_reg;
  logic [DATA_WIDTH-1:0] ram_din_reg;
  logic                  s1_rd_reg;
  port_id_t              s1_id_reg;
  logic                  s2_rd_reg;
  port_id_t              s2_id_reg;

  rr_arb2 u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     ({req1_valid, req0_valid}),
    .gnt     (gnt),
    .gnt_id  (gnt_id),
    .gnt_any (gnt_any)
  );

  assign req0_ready = gnt[0];
  assign req1_ready = gnt[1];

  assign sel_we    = gnt_id ? req1_we    : req0_we;
  assign sel_addr  = gnt_id ? req1_addr  : req0_addr;
  assign sel_wdata = gnt_id ? req1_wdata : req0_wdata;

  // S1 drives the RAM port; S2 lines up with the RAM's registered read data.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ram_we_reg   <= 1'b0;
      ram_addr_reg <= '0;
      ram_din_reg  <= '0;
      s1_rd_reg    <= 1'b0;
      s1_id_reg    <= 1'b0;
      s2_rd_reg    <= 1'b0;
      s2_id_reg    <= 1'b0;
    end else begin
      s2_rd_reg <= s1_rd_reg;
      s2_id_reg <= s1_id_reg;
      if (gnt_any) begin
        ram_we_reg   <= sel_we;
        ram_addr_reg <= sel_addr;
        ram_din_reg  <= sel_wdata;
        s1_rd_reg    <= (sel_we == OP_READ);
        s1_id_reg    <= gnt_id;
      end else begin
        ram_we_reg <= 1'b0;
        s1_rd_reg  <= 1'b0;
      end
    end
  end

  assign ram_we   = ram_we_reg;
  assign ram_addr = ram_addr_reg;
  assign ram_din  = ram_din_reg;

  assign rsp0_valid = s2_rd_reg && (s2_id_reg == 1'b0);
  assign rsp1_valid = s2_rd_reg && (s2_id_reg == 1'b1);
  assign rsp0_rdata = ram_dout;
  assign rsp1_rdata = ram_dout;

endmodule

// File: tb/tb_ram_arbiter.sv
// Scoreboard bench for ram_arbiter: a behavioural RAM, a reference memory model,
// and a negedge monitor that checks grants and matches responses against a queue.
module tb_ram_arbiter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       v [2];
  logic       we [2];
  logic [3:0] addr [2];
  logic [7:0] wd [2];
  logic       rdy [2];
  logic       rsp_v [2];
  logic [7:0] rsp_d [2];
  logic       ram_we;
  logic [3:0] ram_addr;
  logic [7:0] ram_din;
  logic [7:0] ram_dout;

  logic [7:0] ram_mem [16];
  logic [7:0] model_mem [16];

  typedef struct {
    logic       id;
    logic [7:0] data;
    int         due;
  } exp_t;
  exp_t sb[$];

  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  logic model_prio = 1'b0;
  int   wait_cnt [2];
  logic took [2];
  logic rnd_on = 1'b0;

  always #5 clk = ~clk;

  ram_arbiter dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (v[0]),
    .req0_ready (rdy[0]),
    .req0_we    (we[0]),
    .req0_addr  (addr[0]),
    .req0_wdata (wd[0]),
    .req1_valid (v[1]),
    .req1_ready (rdy[1]),
    .req1_we    (we[1]),
    .req1_addr  (addr[1]),
    .req1_wdata (wd[1]),
    .rsp0_valid (rsp_v[0]),
    .rsp0_rdata (rsp_d[0]),
    .rsp1_valid (rsp_v[1]),
    .rsp1_rdata (rsp_d[1]),
    .ram_we     (ram_we),
    .ram_addr   (ram_addr),
    .ram_din    (ram_din),
    .ram_dout   (ram_dout)
  );

  // Single-port RAM, registered read, read-before-write.
  always @(posedge clk) begin
    if (ram_we) ram_mem[ram_addr] <= ram_din;
    ram_dout <= ram_mem[ram_addr];
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor / scoreboard
  always @(negedge clk) begin : mon
    logic [1:0] eg;
    exp_t       e;
    if (!rst_n) begin
      chk("ready_in_reset", {30'd0, rdy[1], rdy[0]}, 32'd0);
      sb.delete();
      model_prio = 1'b0;
      wait_cnt[0] = 0;
      wait_cnt[1] = 0;
    end else begin
      while (sb.size() > 0 && sb[0].due < cyc) begin
        total++;
        bad++;
        $display("FAIL rsp_missing: port %0d got none required data %02h due %0d", sb[0].id, sb[0].data, sb[0].due);
        void'(sb.pop_front());
      end
      for (int p = 0; p < 2; p++) begin
        if (rsp_v[p]) begin
          if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL rsp_unexpected: port %0d got data %02h required no response", p, rsp_d[p]);
          end else begin
            e = sb.pop_front();
            chk("rsp_port", p, {31'd0, e.id});
            chk("rsp_data", {24'd0, rsp_d[p]}, {24'd0, e.data});
            chk("rsp_latency", cyc, e.due);
            $display("rsp port=%0d data=%02h cycle=%0d", p, rsp_d[p], cyc);
          end
        end
      end
      // Expected grant from the arbitration rules
      eg = 2'b00;
      if (v[0] && v[1]) eg = model_prio ? 2'b10 : 2'b01;
      else if (v[0])    eg = 2'b01;
      else if (v[1])    eg = 2'b10;
      chk("grant", {30'd0, rdy[1], rdy[0]}, {30'd0, eg});
      for (int p = 0; p < 2; p++) begin
        if (v[p] && rdy[p]) begin
          took[p] = 1'b1;
          wait_cnt[p] = 0;
`ifndef RAM_ARB_FIXED_PRIO_EN
          model_prio = (p == 0);
`endif
          if (we[p]) begin
            model_mem[addr[p]] = wd[p];
          end else begin
            e.id = (p == 1);
            e.data = model_mem[addr[p]];
            e.due = cyc + 2;
            sb.push_back(e);
          end
        end else if (v[p]) begin
          wait_cnt[p]++;
`ifndef RAM_ARB_FIXED_PRIO_EN
          chk("wait_bound", {31'd0, wait_cnt[p] > 1}, 32'd0);
`endif
        end
      end
    end
  end

  // Random driver: holds a command until it is accepted
  always @(posedge clk) begin
    if (rnd_on) begin
      #1;
      for (int p = 0; p < 2; p++) begin
        if (!v[p] || took[p]) begin
          took[p] = 1'b0;
          v[p] = ($urandom_range(0, 3) != 0);
          we[p] = $urandom_range(0, 1) == 1;
          addr[p] = 4'($urandom_range(0, 15));
          wd[p] = 8'($urandom);
        end
      end
    end
  end

  task automatic clear_reqs();
    for (int p = 0; p < 2; p++) begin
      v[p] = 1'b0;
      we[p] = 1'b0;
      addr[p] = 4'd0;
      wd[p] = 8'd0;
      took[p] = 1'b0;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // Drive one command on port p and return one cycle after acceptance.
  task automatic issue(input int p, input logic w, input logic [3:0] a, input logic [7:0] d);
    bit done;
    done = 0;
    v[p] = 1'b1;
    we[p] = w;
    addr[p] = a;
    wd[p] = d;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk);
      if (rdy[p]) done = 1;
      @(posedge clk);
      #1;
    end
    v[p] = 1'b0;
    if (!done) begin
      total++;
      bad++;
      $display("FAIL issue_timeout: port %0d got no ready required ready within 20 cycles", p);
    end
  endtask

  initial begin
    int acc [2];
    for (int i = 0; i < 16; i++) begin
      ram_mem[i] = 8'd0;
      model_mem[i] = 8'd0;
    end
    clear_reqs();
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Idle after reset
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("idle_ram_we", {31'd0, ram_we}, 32'd0);
      chk("idle_rsp", {30'd0, rsp_v[1], rsp_v[0]}, 32'd0);
      if (i == 0) chk("idle_ram_port", {20'd0, ram_addr, ram_din}, 32'd0);
    end
    @(posedge clk); #1;

    // Write then read on port 0
    issue(0, 1'b1, 4'd3, 8'hA5);
    @(negedge clk);
    chk("wr_ram_port", {19'd0, ram_we, ram_addr, ram_din}, {19'd0, 1'b1, 4'd3, 8'hA5});
    @(posedge clk); #1;
    issue(0, 1'b0, 4'd3, 8'h00);
    @(negedge clk);
    @(negedge clk);
    chk("rd_rsp0", {23'd0, rsp_v[0], rsp_d[0]}, {23'd0, 1'b1, 8'hA5});
    chk("rd_rsp1_quiet", {31'd0, rsp_v[1]}, 32'd0);
    @(posedge clk); #1;

    // Contention: both ports read every cycle
    issue(0, 1'b1, 4'd1, 8'h5A);
    issue(1, 1'b1, 4'd2, 8'hC3);
    do_reset();
    v[0] = 1'b1; we[0] = 1'b0; addr[0] = 4'd1;
    v[1] = 1'b1; we[1] = 1'b0; addr[1] = 4'd2;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
`ifdef RAM_ARB_FIXED_PRIO_EN
      chk("contend_grant", {30'd0, rdy[1], rdy[0]}, 32'd1);
`else
      chk("contend_grant", {30'd0, rdy[1], rdy[0]}, (i % 2 == 0) ? 32'd1 : 32'd2);
`endif
      @(posedge clk); #1;
    end
    clear_reqs();
    repeat (4) @(posedge clk); #1;

    // Port 1 writes addr 15, then both read it together
    issue(1, 1'b1, 4'd15, 8'h3C);
    v[0] = 1'b1; we[0] = 1'b0; addr[0] = 4'd15;
    v[1] = 1'b1; we[1] = 1'b0; addr[1] = 4'd15;
    acc[0] = -1;
    acc[1] = -1;
    for (int i = 0; i < 6 && (v[0] || v[1]); i++) begin
      @(negedge clk);
      for (int p = 0; p < 2; p++) if (v[p] && rdy[p]) acc[p] = cyc;
      @(posedge clk); #1;
      for (int p = 0; p < 2; p++) if (acc[p] >= 0) v[p] = 1'b0;
    end
    chk("both_accepted", {30'd0, acc[1] >= 0, acc[0] >= 0}, 32'd3);
    chk("consecutive", (acc[0] > acc[1]) ? acc[0] - acc[1] : acc[1] - acc[0], 32'd1);
    clear_reqs();
    repeat (4) @(posedge clk); #1;

    // Reset right after a read handshake
    issue(0, 1'b0, 4'd3, 8'h00);
    rst_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("rst_no_rsp", {30'd0, rsp_v[1], rsp_v[0]}, 32'd0);
      if (i == 1) begin
        @(posedge clk);
        #1 rst_n = 1'b1;
      end
    end
    @(posedge clk); #1;
    v[0] = 1'b1; v[1] = 1'b1; we[0] = 1'b0; we[1] = 1'b0;
    @(negedge clk);
    chk("prio_after_rst", {30'd0, rdy[1], rdy[0]}, 32'd1);
    @(posedge clk); #1;
    clear_reqs();
    repeat (4) @(posedge clk); #1;

    // Pre-fill, then random mixed traffic
    do_reset();
    for (int i = 0; i < 16; i++) issue(0, 1'b1, 4'(i), 8'(i * 8'h11));
    rnd_on = 1'b1;
    repeat (1000) @(posedge clk);
    #2;
    rnd_on = 1'b0;
    clear_reqs();
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("drained", sb.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
